oam_dma: RTL and testbench

Sprite-DMA sequencer and memory-port arbiter between the CPU and the shared 64 KiB memory. A CPU write to 0x4014 starts the transfer. The block then stalls the CPU, takes over the memory read/write ports and copies 256 bytes from CPU page `{page,8'h00}` into PPU OAM. It then returns the ports to the CPU.

---
 rtl/oam_dma.sv | 136 +++++++++++++
 tb/tb_oam_dma.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma
// Purpose  : Sprite-DMA sequencer and memory-port arbiter. A CPU write to
//            DMA_REG stalls the CPU, copies 256 bytes from page {page,8'h00}
//            into PPU OAM, then hands the memory ports back to the CPU.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   OAM_DMA_ALIGN_EN  when defined, a transfer triggered on an odd (parity==1)
//                     cycle inserts one extra ALIGN cycle (514 stall cycles
//                     instead of 513).
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   cpu_raddr/cpu_wen/
//   cpu_waddr/cpu_wdata        CPU memory requests (mirrored while idle)
//   cpu_stall                  high while the transfer owns memory
//   mem_raddr/mem_rdata        shared memory read port (rdata registered,
//                              one cycle of latency)
//   mem_wen/mem_waddr/
//   mem_wdata                  shared memory write port
//   oam_wen/oam_addr/oam_wdata OAM byte write interface
// ============================================================================
module oam_dma #(
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_raddr,
    input  logic        cpu_wen,
    input  logic [15:0] cpu_waddr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_stall,
    output logic [15:0] mem_raddr,
    input  logic [7:0]  mem_rdata,
    output logic        mem_wen,
    output logic [15:0] mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        oam_wen,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DUMMY = 3'd1,
`ifdef OAM_DMA_ALIGN_EN
        S_ALIGN = 3'd2,
`endif
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state_q;
    logic [7:0]  page_q;
    logic [7:0]  idx_q;
`ifdef OAM_DMA_ALIGN_EN
    logic        parity_q;   // free-running cycle parity
    logic        align_q;    // parity captured on the trigger edge
`endif

    logic w_trigger;
    logic w_busy;

    assign w_trigger = cpu_wen && (cpu_waddr == DMA_REG);
    assign w_busy    = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= 1'b0;
            align_q  <= 1'b0;
`endif
        end else begin
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= ~parity_q;
`endif
            case (state_q)
                S_IDLE: begin
                    if (w_trigger) begin
                        page_q  <= cpu_wdata;
                        idx_q   <= 8'h00;
                        state_q <= S_DUMMY;
`ifdef OAM_DMA_ALIGN_EN
                        align_q <= parity_q;
`endif
                    end
                end
                S_DUMMY: begin
`ifdef OAM_DMA_ALIGN_EN
                    state_q <= align_q ? S_ALIGN : S_READ;
`else
                    state_q <= S_READ;
`endif
                end
`ifdef OAM_DMA_ALIGN_EN
                S_ALIGN: state_q <= S_READ;
`endif
                S_READ:  state_q <= S_WRITE;
                S_WRITE: begin
                    // idx wraps to zero on exit only; page is never incremented
                    idx_q <= idx_q + 8'd1;
                    if (idx_q == 8'hFF) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_READ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Ports mirror the CPU while idle; during a transfer the read address is
    // the DMA pointer and CPU writes are suppressed.
    always_comb begin
        cpu_stall = w_busy;
        mem_raddr = w_busy ? {page_q, idx_q} : cpu_raddr;
        mem_wen   = w_busy ? 1'b0 : cpu_wen;
        mem_waddr = cpu_waddr;
        mem_wdata = cpu_wdata;
        oam_wen   = 1'b0;
        oam_addr  = 8'h00;
        oam_wdata = 8'h00;
        if (state_q == S_WRITE) begin
            oam_wen   = 1'b1;
            oam_addr  = idx_q;
            oam_wdata = mem_rdata;   // byte requested in the preceding READ
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma
// Purpose  : Self-checking bench for oam_dma. A behavioural 64 KiB memory with
//            one cycle of read latency and an OAM model surround the DUT; each
//            trigger pushes the 256 expected OAM writes into a scoreboard that
//            a negedge monitor pops as oam_wen pulses appear.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_raddr;
    logic        cpu_wen;
    logic [15:0] cpu_waddr;
    logic [7:0]  cpu_wdata;
    logic        cpu_stall;
    logic [15:0] mem_raddr;
    logic [7:0]  mem_rdata;
    logic        mem_wen;
    logic [15:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        oam_wen;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;

    always #5 clk = ~clk;

    oam_dma #(.DMA_REG(16'h4014)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_raddr (cpu_raddr),
        .cpu_wen   (cpu_wen),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .oam_wen   (oam_wen),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata)
    );

    logic [7:0] mem   [0:65535];
    logic [7:0] oam_m [0:255];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } sb_t;
    sb_t sb_q[$];

    int         n_cmp = 0;
    int         n_err = 0;
    int         stall_cnt = 0;
    int         pops = 0;
    int         first_at = 0;
    logic [7:0] cur_page = 8'h00;
    logic       tb_par;

    // Memory: read data registered, sampled before the same-edge write.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_raddr];
        if (mem_wen) mem[mem_waddr] = mem_wdata;
    end

    // Cycle parity as the design should see it.
    always @(posedge clk) tb_par <= reset ? 1'b0 : ~tb_par;

    // Monitor: stall accounting and scoreboard pops.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (cpu_stall === 1'b1) begin
                stall_cnt++;
                n_cmp++;
                if (mem_raddr[15:8] !== cur_page) begin
                    n_err++;
                    $display("FAIL stall_rpage: mem_raddr=%h page=%h", mem_raddr, cur_page);
                end
                if (cpu_wen === 1'b1) begin
                    n_cmp++;
                    if (mem_wen !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_mem_wen: got %b want 0", mem_wen);
                    end
                end
            end
            if (oam_wen === 1'b1) begin
                pops++;
                if (pops == 1) first_at = stall_cnt;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL oam_unexpected: addr=%h data=%h want no write", oam_addr, oam_wdata);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (oam_addr !== e.a || oam_wdata !== e.d) begin
                        n_err++;
                        $display("FAIL oam_write: got %h/%h want %h/%h", oam_addr, oam_wdata, e.a, e.d);
                    end
                end
                if (cpu_stall !== 1'b1) begin
                    n_err++;
                    $display("FAIL oam_no_stall: cpu_stall=%b want 1", cpu_stall);
                end
                oam_m[oam_addr] = oam_wdata;
            end
        end
    end

    // Drive a trigger write for page pg on an edge whose parity equals want.
    task automatic trigger(input logic [7:0] pg, input logic want, input bit push,
                           output logic par_e);
        @(negedge clk); #1;
        if (tb_par !== want) begin
            @(negedge clk); #1;
        end
        par_e     = tb_par;
        cpu_wen   = 1'b1;
        cpu_waddr = 16'h4014;
        cpu_wdata = pg;
        if (push) begin
            for (int k = 0; k < 256; k++) sb_q.push_back({k[7:0], mem[{pg, k[7:0]}]});
        end
        cur_page  = pg;
        stall_cnt = 0;
        pops      = 0;
        first_at  = 0;
        @(negedge clk); #1;
        cpu_wen   = 1'b0;
    endtask

    task automatic wait_done(output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (cpu_stall !== 1'b1) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_cmp++;
        if (cpu_stall !== 1'b0 || oam_wen !== 1'b0 || oam_addr !== 8'h00 || oam_wdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: stall=%b wen=%b addr=%h data=%h want 0/0/00/00",
                     cpu_stall, oam_wen, oam_addr, oam_wdata);
        end
        n_cmp++;
        if (mem_raddr !== 16'h1111) begin
            n_err++;
            $display("FAIL reset_mirror: mem_raddr=%h want 1111", mem_raddr);
        end
        reset = 1'b0;
    endtask

    task automatic test_passthrough;
        @(negedge clk); #1;
        cpu_wen = 1'b1; cpu_waddr = 16'h1234; cpu_wdata = 8'h3C;
        #1;
        n_cmp++;
        if (mem_wen !== 1'b1 || mem_waddr !== 16'h1234 || mem_wdata !== 8'h3C) begin
            n_err++;
            $display("FAIL pass_write: wen=%b addr=%h data=%h want 1/1234/3c", mem_wen, mem_waddr, mem_wdata);
        end
        @(negedge clk); #1;
        cpu_wen = 1'b0; cpu_raddr = 16'h1234;
        #1;
        n_cmp++;
        if (mem_raddr !== 16'h1234) begin
            n_err++;
            $display("FAIL pass_raddr: got %h want 1234", mem_raddr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (mem_rdata !== 8'h3C || mem[16'h1234] !== 8'h3C) begin
            n_err++;
            $display("FAIL pass_read: rdata=%h mem=%h want 3c", mem_rdata, mem[16'h1234]);
        end
        cpu_raddr = 16'h1111;
    endtask

    // One full transfer with timing, content and hand-back checks.
    task automatic test_transfer(input logic [7:0] pg, input logic want_par, input string tag);
        logic par_e;
        bit   to;
        int   exp_stall;
        trigger(pg, want_par, 1'b1, par_e);
        wait_done(to);
        exp_stall = (ALIGN_ON && par_e) ? 514 : 513;
        n_cmp++;
        if (to || stall_cnt != exp_stall) begin
            n_err++;
            $display("FAIL %s_stall: got %0d cycles (timeout=%0d) want %0d", tag, stall_cnt, to, exp_stall);
        end
        n_cmp++;
        if (pops != 256 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_count: got %0d writes, %0d pending want 256, 0", tag, pops, sb_q.size());
        end
        n_cmp++;
        if (first_at != exp_stall - 510) begin
            n_err++;
            $display("FAIL %s_latency: first write at stall cycle %0d want %0d", tag, first_at, exp_stall - 510);
        end
        n_cmp++;
        if (mem_raddr !== 16'h1111 || cpu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL %s_handback: mem_raddr=%h stall=%b want 1111/0", tag, mem_raddr, cpu_stall);
        end
        sb_q.delete();
    endtask

    task automatic test_basic;
        test_transfer(8'h02, tb_par, "basic");
        for (int k = 0; k < 256; k++) begin
            n_cmp++;
            if (oam_m[k] !== (k[7:0] ^ 8'hA5)) begin
                n_err++;
                $display("FAIL basic_oam[%0d]: got %h want %h", k, oam_m[k], k[7:0] ^ 8'hA5);
            end
        end
    endtask

    task automatic test_align;
        test_transfer(8'h02, 1'b1, "align_p1");
        test_transfer(8'h02, 1'b0, "align_p0");
    endtask

    task automatic test_page_ff;
        test_transfer(8'hFF, tb_par, "page_ff");
    endtask

    task automatic test_stall_write;
        logic par_e;
        bit   to;
        trigger(8'h02, tb_par, 1'b1, par_e);
        cpu_wen = 1'b1; cpu_waddr = 16'h0300; cpu_wdata = 8'h77;
        repeat (50) @(negedge clk);
        #1;
        cpu_wen = 1'b0;
        wait_done(to);
        n_cmp++;
        if (to || stall_cnt != ((ALIGN_ON && par_e) ? 514 : 513)) begin
            n_err++;
            $display("FAIL stallwr_stall: got %0d cycles want %0d", stall_cnt, (ALIGN_ON && par_e) ? 514 : 513);
        end
        n_cmp++;
        if (mem[16'h0300] !== 8'h5A) begin
            n_err++;
            $display("FAIL stallwr_mem: mem[0300]=%h want 5a", mem[16'h0300]);
        end
        sb_q.delete();
    endtask

    task automatic test_reset_trigger;
        @(negedge clk); #1;
        reset = 1'b1;
        cpu_wen = 1'b1; cpu_waddr = 16'h4014; cpu_wdata = 8'h02;
        @(negedge clk); #1;
        reset = 1'b0; cpu_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cpu_stall !== 1'b0) begin
                n_err++;
                $display("FAIL rst_trig_stall: cycle %0d stall=%b want 0", i, cpu_stall);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset_mid;
        logic par_e;
        bit   hit;
        trigger(8'h05, tb_par, 1'b1, par_e);
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (pops >= 100) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL mid_reach100: got %0d writes want 100", pops);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (cpu_stall !== 1'b0 || oam_wen !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_out: stall=%b oam_wen=%b want 0/0", cpu_stall, oam_wen);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 156 || cpu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL mid_pending: got %0d pending stall=%b want 156/0", sb_q.size(), cpu_stall);
        end
        for (int k = 0; k < 256; k++) begin
            logic [7:0] ev;
            ev = (k < 100) ? (k[7:0] ^ 8'h5C) : (k[7:0] ^ 8'hA5);
            n_cmp++;
            if (oam_m[k] !== ev) begin
                n_err++;
                $display("FAIL mid_oam[%0d]: got %h want %h", k, oam_m[k], ev);
            end
        end
        sb_q.delete();
        test_transfer(8'h05, tb_par, "after_reset");
    endtask

    initial begin
        reset     = 1'b1;
        cpu_raddr = 16'h1111;
        cpu_wen   = 1'b0;
        cpu_waddr = 16'h0000;
        cpu_wdata = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = i[7:0] ^ 8'hA5;
            mem[16'h0500 + i] = i[7:0] ^ 8'h5C;
            mem[16'hFF00 + i] = 8'($urandom_range(0, 255));
            oam_m[i]          = 8'h00;
        end
        mem[16'h0000] = 8'hEE;
        mem[16'h0300] = 8'h5A;
        repeat (3) @(negedge clk);

        test_reset();
        test_passthrough();
        test_basic();
        test_align();
        test_page_ff();
        test_stall_write();
        test_reset_trigger();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
